// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - sequential shift-add WIDTH x WIDTH multiplier, signed/unsigned
// One shift-add step per multiplier bit; sign is handled by multiplying magnitudes and negating the result.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               mode_r;
  logic               neg_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   mplr_r;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               last_step;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_hi_nxt;
  logic [WIDTH-1:0]   mplr_nxt;
  logic [2*WIDTH-1:0] result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  // -2^(WIDTH-1) negates to itself, which read unsigned is exactly its magnitude.
  assign a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

  // The carry lands in sum[WIDTH] and is shifted back into the accumulator top bit.
  assign sum        = {1'b0, acc_hi} + (mplr_r[0] ? {1'b0, mcand_r} : '0);
  assign acc_hi_nxt = sum[WIDTH:1];
  assign mplr_nxt   = {sum[0], mplr_r[WIDTH-1:1]};
  assign result     = (mode_r && neg_r) ? -{acc_hi_nxt, mplr_nxt} : {acc_hi_nxt, mplr_nxt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r  <= 1'b0;
      neg_r   <= 1'b0;
      mcand_r <= '0;
      acc_hi  <= '0;
      mplr_r  <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      mode_r  <= signed_mode;
      neg_r   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      mcand_r <= a_mag;
      mplr_r  <= b_mag;
      acc_hi  <= '0;
      cnt     <= '0;
    end else if (state == BUSY) begin
      acc_hi <= acc_hi_nxt;
      mplr_r <= mplr_nxt;
      cnt    <= cnt + CNT_W'(1);
      if (last_step) product <= result;
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb/tb_seq_shift_add_multiplier.sv - self-checking bench for WIDTH=4 and WIDTH=8 instances
module tb_seq_shift_add_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       iv4, ir4, sm4, ov4, ordy4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] p4;
  logic       iv8, ir8, sm8, ov8, ordy8, busy8;
  logic [7:0] a8, b8;
  logic [15:0] p8;

  int checks = 0;
  int errors = 0;

  seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .signed_mode(sm4), .out_valid(ov4), .out_ready(ordy4), .product(p4), .busy(busy4)
  );

  seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(ordy8), .product(p8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: interpret operands by mode, multiply as integers, keep 2*w bits.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a, input logic [15:0] b, input bit s);
    longint sa, sb, mask;
    mask = (64'sd1 <<< w) - 1;
    sa = longint'(a) & mask;
    sb = longint'(b) & mask;
    if (s && sa >= (64'sd1 <<< (w - 1))) sa -= (64'sd1 <<< w);
    if (s && sb >= (64'sd1 <<< (w - 1))) sb -= (64'sd1 <<< w);
    return 32'((sa * sb) & ((64'sd1 <<< (2 * w)) - 1));
  endfunction

  function automatic logic get_ov(input int w);   return (w == 4) ? ov4 : ov8;     endfunction
  function automatic logic get_ir(input int w);   return (w == 4) ? ir4 : ir8;     endfunction
  function automatic logic get_busy(input int w); return (w == 4) ? busy4 : busy8; endfunction
  function automatic logic [31:0] get_p(input int w);
    return (w == 4) ? {24'b0, p4} : {16'b0, p8};
  endfunction

  task automatic drive(input int w, input bit v, input logic [15:0] a, input logic [15:0] b,
                       input bit sm, input bit ordy);
    if (w == 4) begin
      iv4 = v; a4 = a[3:0]; b4 = b[3:0]; sm4 = sm; ordy4 = ordy;
    end else begin
      iv8 = v; a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; ordy8 = ordy;
    end
  endtask

  // One full operation: accept, wait for result, optionally hold backpressure, release.
  task automatic op(input int w, input logic [15:0] a, input logic [15:0] b, input bit sm,
                    input bit toggle, input int hold, input string tag);
    logic [31:0] exp;
    int lat;
    exp = ref_mul(w, a, b, sm);
    @(negedge clk);
    check({tag, "_in_ready_idle"}, 64'(get_ir(w)), 64'd1);
    drive(w, 1'b1, a, b, sm, 1'b0);
    @(negedge clk);
    drive(w, 1'b0, a, b, sm, 1'b0);
    lat = 0;
    while (!get_ov(w) && lat < 64) begin
      check({tag, "_busy"}, 64'(get_busy(w)), 64'd1);
      if (toggle) drive(w, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(w));
    check({tag, "_product"}, 64'(get_p(w)), 64'(exp));
    check({tag, "_in_ready_done"}, 64'(get_ir(w)), 64'd0);
    for (int i = 0; i < hold; i++) begin
      drive(w, 1'b1, 16'd1, 16'd1, 1'b0, 1'b0);
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(get_ov(w)), 64'd1);
      check({tag, "_hold_product"}, 64'(get_p(w)), 64'(exp));
      check({tag, "_hold_in_ready"}, 64'(get_ir(w)), 64'd0);
    end
    drive(w, 1'b0, a, b, sm, 1'b1);
    @(negedge clk);
    check({tag, "_released_valid"}, 64'(get_ov(w)), 64'd0);
    check({tag, "_released_in_ready"}, 64'(get_ir(w)), 64'd1);
    check({tag, "_released_product"}, 64'(get_p(w)), 64'(exp));
    drive(w, 1'b0, a, b, sm, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    drive(8, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_in_ready4", 64'(ir4), 64'd1);
    check("reset_out_valid4", 64'(ov4), 64'd0);
    check("reset_busy4", 64'(busy4), 64'd0);
    check("reset_product4", 64'(p4), 64'd0);
    check("reset_in_ready8", 64'(ir8), 64'd1);
    check("reset_product8", 64'(p8), 64'd0);
    rst_n = 1'b1;

    op(4, 16'hF, 16'hF, 1'b0, 1'b0, 0, "u15x15");
    check("u15x15_const", 64'(p4), 64'hE1);
    op(4, 16'h8, 16'h8, 1'b1, 1'b0, 0, "s_m8xm8");
    check("s_m8xm8_const", 64'(p4), 64'h40);
    op(4, 16'hD, 16'h5, 1'b1, 1'b0, 0, "s_m3x5");
    check("s_m3x5_const", 64'(p4), 64'hF1);
    op(4, 16'h7, 16'hF, 1'b1, 1'b0, 0, "s_7xm1");
    check("s_7xm1_const", 64'(p4), 64'hF9);
    op(4, 16'h0, 16'h9, 1'b1, 1'b0, 0, "s_zero");

    op(4, 16'd3, 16'd5, 1'b0, 1'b0, 10, "backpressure");
    op(4, 16'd6, 16'd7, 1'b0, 1'b0, 0, "after_bp");

    @(negedge clk);
    drive(4, 1'b1, 16'd3, 16'd3, 1'b0, 1'b0);
    @(negedge clk);
    drive(4, 1'b0, 16'd3, 16'd3, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(ov4), 64'd0);
    check("midreset_product", 64'(p4), 64'd0);
    check("midreset_in_ready", 64'(ir4), 64'd1);
    check("midreset_busy", 64'(busy4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(4, 16'd2, 16'd6, 1'b0, 1'b0, 0, "after_reset");
    check("after_reset_const", 64'(p4), 64'h0C);

    op(4, 16'd9, 16'd9, 1'b0, 1'b1, 0, "toggle");
    check("toggle_const", 64'(p4), 64'h51);

    op(8, 16'hFF, 16'hFF, 1'b0, 1'b0, 0, "w8_u255");
    check("w8_u255_const", 64'(p8), 64'hFE01);
    op(8, 16'h80, 16'h7F, 1'b1, 1'b0, 0, "w8_s_m128x127");
    check("w8_s_m128x127_const", 64'(p8), 64'hC080);
    op(8, 16'h80, 16'h80, 1'b1, 1'b0, 0, "w8_s_m128xm128");

    for (int i = 0; i < 1000; i++)
      op(8, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 0, "rnd8");
    for (int i = 0; i < 200; i++)
      op(4, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "rnd4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
